envelope_vca: RTL and testbench
===============================

// Module: envelope_vca
// PURPOSE
//   ADSR envelope generator plus voltage-controlled amplifier (VCA) on the 8-bit mixer output.
//   Sits directly downstream of the 6-channel waveform mixer and feeds the PWM/DAC output stage.
//   Gate and all rates come from I2C registers. The multiply is a single registered 8x8 product.
// PARAMETERS
//   PRESCALE  256  clk cycles per envelope tick (>=2); tb uses 4
//   PRE_W     8    prescaler counter width, must satisfy 2^PRE_W >= PRESCALE
// PORTS
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active-high
//   mixed_in     in   8  unsigned sample from the mixer (registered upstream)
//   gate         in   1  note gate, level-sensitive (I2C bit)
//   attack_rate  in   8  env ticks per attack step, minus 1
//   decay_rate   in   8  env ticks per decay step, minus 1
//   sustain_lvl  in   8  sustain level, 0..255
//   release_rate in   8  env ticks per release step, minus 1
//   audio_out    out  8  enveloped sample
//   env_level    out  8  current envelope level
//   env_state    out  3  0=IDLE 1=ATTACK 2=DECAY 3=SUSTAIN 4=RELEASE
//   env_active   out  1  high when env_state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, level=0, audio_out=0, prescaler=0, rate counter=0, gate_d=0.
//   Prescaler: counts 0..PRESCALE-1 and asserts env_tick for one clk at PRESCALE-1, then wraps.
//   Rate counter: advances on env_tick. A step fires when rate counter == active phase rate; the counter then clears.
//     The counter also clears on every state change.
//     rate=0 gives one step per env_tick. rate=255 gives one step per 256 env_ticks.
//   Gate edges: gate_d is gate registered one cycle. rise = gate & ~gate_d; fall = ~gate & gate_d.
//   Transitions are evaluated each clk, in this priority order:
//     1. rise (any state) -> ATTACK. Level is kept; there is no reset to 0 (legato retrigger).
//     2. fall in ATTACK/DECAY/SUSTAIN -> RELEASE.
//     3. ATTACK step: level+1. Reaching 255 -> DECAY on the same step.
//     4. DECAY step: level-dec. If result <= sustain_lvl, clamp to sustain_lvl and go to SUSTAIN.
//        If sustain_lvl==255 on entry, go to SUSTAIN on the first step.
//     5. SUSTAIN: level tracks sustain_lvl every clk, so live edits apply immediately.
//     6. RELEASE step: level-dec, saturating at 0. Reaching 0 -> IDLE.
//     7. IDLE: level held at 0.
//   Gate held high through reset release: gate_d is 0 after reset, so a rise is seen -> ATTACK.
//   Arithmetic: all level math is unsigned 8-bit with saturation; never wraps 255->0 or 0->255.
//   VCA: audio_out <= (mixed_in * env_level) >> 8. This uses a 16-bit product, takes bits [15:8], and is registered.
//     Latency is 1 clk from mixed_in/env_level to audio_out.
//     level=255 and mixed_in=255 gives 254. level=0 gives 0.
//   Reset mid-note: all state returns to reset values on the next clk edge, regardless of gate.
// CONFIGURATION
//   ENV_EXP_DECAY_EN defined:
//     decrement dec = (level>>4)+1 in DECAY and RELEASE (exponential-like curve).
//     Underflow clamps to sustain_lvl in DECAY and to 0 in RELEASE.
//   ENV_EXP_DECAY_EN undefined:
//     dec = 1 (linear). Attack is linear in both builds.
// TESTING (PRESCALE=4)
//   1. rst=1 for 2 clk, then gate=0, mixed_in=0xFF -> audio_out=0, env_level=0, env_state=0, env_active=0.
//   2. attack_rate=0, decay_rate=0, sustain_lvl=0x80, release_rate=0; gate 0->1:
//      env_state=1 within 2 clk; level +1 per 4 clk; 255 after 1020 clk +/-2;
//      then DECAY, then SUSTAIN with env_level=0x80.
//   3. In SUSTAIN with mixed_in=0xC8: audio_out=0x64 one clk later.
//      Write sustain_lvl=0x40 -> env_level=0x40 on next clk; audio_out=0x32 one clk after.
//   4. gate 1->0 at level 0x40, release_rate=1: env_state=4, level -1 per 8 clk (linear build),
//      IDLE after 512 clk +/-8, audio_out=0.
//   5. gate 1->0 mid-ATTACK at level 0x30, then 1 again during RELEASE at level 0x28:
//      env_state=1 and level resumes climbing from 0x28 (no drop to 0).
//   6. ENV_EXP_DECAY_EN build: RELEASE from 0xFF, release_rate=0 -> first step to 0xEF (dec 16).
//      Level reaches 0 without wrap; then IDLE. Also assert rst mid-DECAY -> all outputs 0 next clk.

Source files
------------

// File: rtl/envelope_vca.sv
// ---------------------------------------------------------------------------
// envelope_vca
//   ADSR envelope generator followed by a registered 8x8 VCA multiply.
//   The envelope advances on a prescaled tick, and each phase has its own step
//   rate. audio_out is (mixed_in * env_level) >> 8, registered once.
//
//   Optional build macro: ENV_EXP_DECAY_EN
//     defined   : DECAY/RELEASE decrement is (level>>4)+1 (exponential-like)
//     undefined : DECAY/RELEASE decrement is 1 (linear)
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active-high
//   mixed_in     in   8  unsigned mixer sample
//   gate         in   1  note gate (level-sensitive)
//   attack_rate  in   8  env ticks per attack step, minus 1
//   decay_rate   in   8  env ticks per decay step, minus 1
//   sustain_lvl  in   8  sustain level
//   release_rate in   8  env ticks per release step, minus 1
//   audio_out    out  8  enveloped sample
//   env_level    out  8  current envelope level
//   env_state    out  3  0=IDLE 1=ATTACK 2=DECAY 3=SUSTAIN 4=RELEASE
//   env_active   out  1  env_state != IDLE
// ---------------------------------------------------------------------------
module envelope_vca #(
   parameter int PRESCALE = 256,
   parameter int PRE_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] mixed_in,
   input  logic       gate,
   input  logic [7:0] attack_rate,
   input  logic [7:0] decay_rate,
   input  logic [7:0] sustain_lvl,
   input  logic [7:0] release_rate,
   output logic [7:0] audio_out,
   output logic [7:0] env_level,
   output logic [2:0] env_state,
   output logic       env_active
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ATTACK  = 3'd1;
   localparam logic [2:0] ST_DECAY   = 3'd2;
   localparam logic [2:0] ST_SUSTAIN = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [7:0]       rate_q, rate_d;
   logic [2:0]       state_q, state_d;
   logic [7:0]       level_q, level_d;
   logic [7:0]       audio_q, audio_d;
   logic             gate_q;

   logic             env_tick;
   logic             step;
   logic             rise, fall;
   logic [7:0]       cur_rate;
   logic [7:0]       dec;
   logic [15:0]      product;

   // Prescaler: free-running, one-cycle tick on its last count.
   assign env_tick = (pre_q == PRE_LAST);
   assign pre_d    = env_tick ? '0 : pre_q + 1'b1;

   assign rise = gate & ~gate_q;
   assign fall = ~gate & gate_q;

   always_comb begin
      cur_rate = 8'd0;
      case (state_q)
         ST_ATTACK:  cur_rate = attack_rate;
         ST_DECAY:   cur_rate = decay_rate;
         ST_RELEASE: cur_rate = release_rate;
         default:    cur_rate = 8'd0;
      endcase
   end

   assign step = env_tick && (rate_q == cur_rate);

`ifdef ENV_EXP_DECAY_EN
   // Larger steps at high levels give an exponential-looking fall.
   assign dec = {4'd0, level_q[7:4]} + 8'd1;
`else
   assign dec = 8'd1;
`endif

   always_comb begin
      state_d = state_q;
      level_d = level_q;

      if (rise) begin
         // Legato retrigger: level is kept, attack resumes from here.
         state_d = ST_ATTACK;
      end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                            state_q == ST_SUSTAIN)) begin
         state_d = ST_RELEASE;
      end else begin
         case (state_q)
            ST_ATTACK: begin
               if (step) begin
                  level_d = (level_q == 8'hFF) ? 8'hFF : level_q + 8'd1;
                  if (level_d == 8'hFF) state_d = ST_DECAY;
               end
            end
            ST_DECAY: begin
               if (step) begin
                  // level <= dec covers underflow; sustain 255 always lands here first step.
                  if ((level_q <= dec) || ((level_q - dec) <= sustain_lvl)) begin
                     level_d = sustain_lvl;
                     state_d = ST_SUSTAIN;
                  end else begin
                     level_d = level_q - dec;
                  end
               end
            end
            ST_SUSTAIN: begin
               // Tracks the register every cycle so live edits apply at once.
               level_d = sustain_lvl;
            end
            ST_RELEASE: begin
               if (step) begin
                  if (level_q <= dec) begin
                     level_d = 8'd0;
                     state_d = ST_IDLE;
                  end else begin
                     level_d = level_q - dec;
                  end
               end
            end
            default: begin
               level_d = 8'd0;
            end
         endcase
      end
   end

   // Rate counter: advances on ticks, clears on a step and on any state change.
   always_comb begin
      rate_d = rate_q;
      if (env_tick) rate_d = step ? 8'd0 : rate_q + 8'd1;
      if (state_d != state_q) rate_d = 8'd0;
   end

   assign product = 16'(mixed_in) * 16'(level_q);
   assign audio_d = product[15:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q   <= '0;
         rate_q  <= 8'd0;
         state_q <= ST_IDLE;
         level_q <= 8'd0;
         audio_q <= 8'd0;
         gate_q  <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         rate_q  <= rate_d;
         state_q <= state_d;
         level_q <= level_d;
         audio_q <= audio_d;
         gate_q  <= gate;
      end
   end

   assign audio_out  = audio_q;
   assign env_level  = level_q;
   assign env_state  = state_q;
   assign env_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_envelope_vca.sv
// ---------------------------------------------------------------------------
// tb_envelope_vca
//   Directed bench for envelope_vca with PRESCALE=4. A vector table exercises
//   the VCA in SUSTAIN; hand-written sequences cover attack/decay timing,
//   release, legato retrigger, release from full scale and reset mid-note.
//   Expected decrements follow ENV_EXP_DECAY_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_envelope_vca;

   localparam int PRESCALE = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] mixed_in;
   logic       gate;
   logic [7:0] attack_rate, decay_rate, sustain_lvl, release_rate;
   logic [7:0] audio_out, env_level;
   logic [2:0] env_state;
   logic       env_active;

   envelope_vca #(.PRESCALE(PRESCALE), .PRE_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .mixed_in     (mixed_in),
      .gate         (gate),
      .attack_rate  (attack_rate),
      .decay_rate   (decay_rate),
      .sustain_lvl  (sustain_lvl),
      .release_rate (release_rate),
      .audio_out    (audio_out),
      .env_level    (env_level),
      .env_state    (env_state),
      .env_active   (env_active)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] mixed;
      logic [7:0] sus;
      logic [7:0] exp_level;
      logic [7:0] exp_audio;
   } vec_t;

   vec_t       vecs[11];
   logic [7:0] exp_q[$];

   // driver / checker tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic int dec_of(input int lvl);
`ifdef ENV_EXP_DECAY_EN
      return (lvl >> 4) + 1;
`else
      return 1;
`endif
   endfunction

   int n, c0, prev, lv, steps, exp_clk, t1, t2, wrap;
   logic [7:0] exp_a;

   initial begin
      vecs[0]  = '{8'hC8, 8'h80, 8'h80, 8'h64};
      vecs[1]  = '{8'hC8, 8'h40, 8'h40, 8'h32};
      vecs[2]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFE};
      vecs[3]  = '{8'hFF, 8'h00, 8'h00, 8'h00};
      vecs[4]  = '{8'h80, 8'h80, 8'h80, 8'h40};
      vecs[5]  = '{8'h01, 8'hFF, 8'hFF, 8'h00};
      vecs[6]  = '{8'hFF, 8'h01, 8'h01, 8'h00};
      vecs[7]  = '{8'h10, 8'h10, 8'h10, 8'h01};
      vecs[8]  = '{8'hAA, 8'h55, 8'h55, 8'h38};
      vecs[9]  = '{8'hFF, 8'h80, 8'h80, 8'h7F};
      vecs[10] = '{8'hC8, 8'h40, 8'h40, 8'h32};

      // 1. reset
      rst = 1'b1; gate = 1'b0; mixed_in = 8'hFF;
      attack_rate = 8'd0; decay_rate = 8'd0; sustain_lvl = 8'h80; release_rate = 8'd0;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("reset_audio", audio_out, 8'd0);
      check("reset_level", env_level, 8'd0);
      check("reset_state", env_state, 3'd0);
      check("reset_active", env_active, 1'b0);

      // 2. attack / decay / sustain
      gate = 1'b1;
      c0 = cyc;
      tick(1);
      check("attack_entry_state", env_state, 3'd1);
      check("attack_entry_active", env_active, 1'b1);
      for (int k = 0; k < 3; k++) begin
         prev = env_level; n = 0;
         while (env_level === prev[7:0] && n < 8) begin tick(1); n++; end
         if (k > 0) check("attack_step_period", n, PRESCALE);
      end
      n = 0;
      while (env_level !== 8'hFF && n < 1200) begin tick(1); n++; end
      check("attack_reach_255", env_level, 8'hFF);
      check_range("attack_time", cyc - c0, 1016, 1024);
      check("attack_to_decay", env_state, 3'd2);
      n = 0;
      while (env_level === 8'hFF && n < 8) begin tick(1); n++; end
      check("decay_first_step", env_level, 255 - dec_of(255));
      n = 0;
      while (env_state !== 3'd3 && n < 1500) begin tick(1); n++; end
      check("sustain_state", env_state, 3'd3);
      check("sustain_level", env_level, 8'h80);

      // 3. VCA vectors in SUSTAIN
      for (int i = 0; i < 11; i++) begin
         mixed_in = vecs[i].mixed;
         sustain_lvl = vecs[i].sus;
         exp_q.push_back(vecs[i].exp_audio);
         tick(1);
         check($sformatf("vec%0d_level", i), env_level, vecs[i].exp_level);
         tick(1);
         exp_a = exp_q.pop_front();
         check($sformatf("vec%0d_audio", i), audio_out, exp_a);
      end

      // 4. release from 0x40, release_rate=1
      release_rate = 8'd1;
      gate = 1'b0;
      tick(1);
      check("release_entry", env_state, 3'd4);
      lv = 64; steps = 0;
      while (lv > 0) begin lv = lv - ((dec_of(lv) > lv) ? lv : dec_of(lv)); steps++; end
      exp_clk = steps * 2 * PRESCALE;
      prev = env_level; wrap = 0; n = 0; t1 = -1; t2 = -1;
      while (env_state !== 3'd0 && n < 1500) begin
         tick(1); n++;
         if (int'(env_level) > prev) wrap = 1;
         if (int'(env_level) != prev) begin
            if (t1 < 0) t1 = n;
            else if (t2 < 0) t2 = n;
         end
         prev = env_level;
      end
      check("release_to_idle", env_state, 3'd0);
      check_range("release_time", n + 1, exp_clk - 8, exp_clk + 8);
      check("release_step_period", t2 - t1, 2 * PRESCALE);
      check("release_no_wrap", wrap, 0);
      tick(1);
      check("idle_level", env_level, 8'd0);
      check("idle_audio", audio_out, 8'd0);
      check("idle_active", env_active, 1'b0);

      // 5. legato retrigger during release
      release_rate = 8'd0;
      mixed_in = 8'hFF;
      gate = 1'b1;
      n = 0;
      while (env_level !== 8'h30 && n < 400) begin tick(1); n++; end
      check("legato_reach_30", env_level, 8'h30);
      gate = 1'b0;
      tick(1);
      check("legato_release_state", env_state, 3'd4);
      check("legato_release_level", env_level, 8'h30);
      n = 0;
      while (env_level > 8'h28 && n < 200) begin tick(1); n++; end
      lv = env_level;
      check_range("legato_release_fell", lv, 1, 8'h28);
      gate = 1'b1;
      tick(1);
      check("legato_attack_state", env_state, 3'd1);
      check("legato_level_kept", env_level, lv);
      tick(3 * PRESCALE);
      check_range("legato_climbing", env_level, lv + 1, lv + 4);

      // 6. release from full scale
      n = 0;
      while (env_level !== 8'hFF && n < 1200) begin tick(1); n++; end
      check("full_reach_255", env_level, 8'hFF);
      gate = 1'b0;
      tick(1);
      check("full_release_state", env_state, 3'd4);
      check("full_release_level", env_level, 8'hFF);
      n = 0;
      while (env_level === 8'hFF && n < 8) begin tick(1); n++; end
      check("full_release_first_step", env_level, 255 - dec_of(255));
      prev = env_level; wrap = 0; n = 0;
      while (env_state !== 3'd0 && n < 1500) begin
         tick(1); n++;
         if (int'(env_level) > prev) wrap = 1;
         prev = env_level;
      end
      check("full_release_idle", env_state, 3'd0);
      check("full_release_level0", env_level, 8'd0);
      check("full_release_no_wrap", wrap, 0);

      // 7. reset mid-DECAY with gate held high
      gate = 1'b1;
      n = 0;
      while (env_state !== 3'd2 && n < 1200) begin tick(1); n++; end
      tick(6);
      check("mid_decay_state", env_state, 3'd2);
      rst = 1'b1;
      tick(1);
      check("rst_mid_audio", audio_out, 8'd0);
      check("rst_mid_level", env_level, 8'd0);
      check("rst_mid_state", env_state, 3'd0);
      check("rst_mid_active", env_active, 1'b0);
      rst = 1'b0;
      tick(1);
      check("gate_through_reset_attack", env_state, 3'd1);
      tick(2);
      check("prescale_after_reset_l0", env_level, 8'd0);
      tick(1);
      check("prescale_after_reset_l1", env_level, 8'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
